// File: rtl/alu_seq_ctrl_if.sv
// Request/response bus of the multi-cycle MUL/DIVU/REMU sequencer.
// The master issues one operation; the slave reports busy, done and the result.
interface alu_seq_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    modport master (output start, op, a, b,
                    input  busy, done, result, div_by_zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, div_by_zero);
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that drives the shared 64-bit ALU to perform shift-add multiply
// (low half) and restoring divide/remainder, one operation at a time.
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          reset,
    alu_seq_ctrl_if.slave bus,
    output logic [63:0]   alu_a,
    output logic [63:0]   alu_b,
    output logic          alu_a_invert,
    output logic          alu_b_invert,
    output logic          alu_carry_in,
    output logic [1:0]    alu_operation,
    input  logic [63:0]   alu_result,
    input  logic          alu_carry_out,
    input  logic          alu_zf
);
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 6;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_DONE} state_e;

    // x: acc / rem, y: mcand / quo (holds a after accept), z: mplier / divisor (holds b)
    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    div_shift_c;
    logic            qbit_c;

    assign div_shift_c = {x_q[W-2:0], y_q[W-1]};
    // A set rem[63] means the shifted 65-bit remainder exceeds any divisor.
    assign qbit_c      = x_q[W-1] | alu_carry_out;

    // ALU drive depends only on state and registers.
    always_comb begin
        alu_a         = '0;
        alu_b         = '0;
        alu_a_invert  = 1'b0;
        alu_b_invert  = 1'b0;
        alu_carry_in  = 1'b0;
        alu_operation = ALU_AND;
        case (state_q)
            S_CHECK: begin
                alu_b         = z_q;
                alu_operation = ALU_OR;
            end
            S_ITER: begin
                alu_operation = ALU_ADD;
                if (op_q == OP_MUL) begin
                    alu_a = x_q;
                    alu_b = z_q[0] ? y_q : '0;
                end else begin
                    alu_a        = div_shift_c;
                    alu_b        = z_q;
                    alu_b_invert = 1'b1;
                    alu_carry_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.op != OP_RSVD)) begin
                    state_d = S_CHECK;
                    op_d    = bus.op;
                    y_d     = bus.a;
                    z_d     = bus.b;
                    x_d     = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CHECK: begin
                if ((op_q != OP_MUL) && alu_zf) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    dbz_d    = 1'b1;
                    result_d = (op_q == OP_DIVU) ? '1 : y_q;
                end else begin
                    state_d = S_ITER;
                    x_d     = '0;
                    count_d = '0;
                end
            end
            S_ITER: begin
                if (op_q == OP_MUL) begin
                    x_d = alu_result;
                    y_d = y_q << 1;
                    z_d = z_q >> 1;
                end else begin
                    x_d = qbit_c ? alu_result : div_shift_c;
                    y_d = {y_q[W-2:0], qbit_c};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    dbz_d    = 1'b0;
                    result_d = (op_q == OP_DIVU) ? y_d : x_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule
